// File: rtl/sha_1_pad.sv
// SHA-1 message formatter: packs a byte stream into 512-bit blocks, appends
// 0x80 / zero fill / 64-bit bit length, and hands each block to the core.
module sha_1_pad (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   In_Data,
  input  logic         In_Valid,
  input  logic         In_Last,
  output logic         In_Ready,
  output logic [511:0] Data,
  output logic [63:0]  Index,
  output logic         Enable,
  input  logic         Ready,
  output logic         Done
);

  typedef enum logic [2:0] {S_LOAD, S_PAD, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [63:0]    len_q, len_d;
  logic [63:0]    idx_q, idx_d;
  logic           last_q, last_d;
  logic           padded_q, padded_d;
  logic           fin_q, fin_d;
  logic [511:0]   blk_q, blk_d;

  // Bit offset of message byte k: word k/4, big-endian within the word.
  function automatic logic [8:0] bpos(input logic [5:0] k);
    return {k[5:2], ~k[1:0], 3'b000};
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    idx_d    = idx_q;
    last_d   = last_q;
    padded_d = padded_q;
    fin_d    = fin_q;
    blk_d    = blk_q;
    In_Ready = 1'b0;
    Enable   = 1'b0;
    Done     = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          blk_d[bpos(cnt_q) +: 8] = In_Data;
          cnt_d = cnt_q + 6'd1;
          len_d = len_q + 64'd8;
          if (cnt_q == 6'd63) begin
            state_d = S_ISSUE;
            idx_d   = idx_q + 64'd1;
            if (In_Last) last_d = 1'b1;
          end else if (In_Last) begin
            last_d  = 1'b1;
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        for (int b = 0; b < 64; b++) begin
          if (!padded_q) begin
            if (6'(b) == cnt_q)     blk_d[bpos(6'(b)) +: 8] = 8'h80;
            else if (6'(b) > cnt_q) blk_d[bpos(6'(b)) +: 8] = 8'h00;
          end else if (b < 56) begin
            blk_d[bpos(6'(b)) +: 8] = 8'h00;
          end
        end
        padded_d = 1'b1;
        // Length fits only if the 0x80 marker left bytes 56..63 free.
        if (padded_q || cnt_q <= 6'd55) begin
          blk_d[479:448] = len_q[63:32];
          blk_d[511:480] = len_q[31:0];
          fin_d          = 1'b1;
        end
        idx_d   = idx_q + 64'd1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        Enable  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Ready) begin
          if (fin_q) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = 6'd0;
            state_d = last_q ? S_PAD : S_LOAD;
          end
        end
      end
      S_DONE: begin
        Done     = 1'b1;
        cnt_d    = 6'd0;
        len_d    = 64'd0;
        idx_d    = 64'd0;
        last_d   = 1'b0;
        padded_d = 1'b0;
        fin_d    = 1'b0;
        state_d  = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_LOAD;
      cnt_q    <= 6'd0;
      len_q    <= 64'd0;
      idx_q    <= 64'd0;
      last_q   <= 1'b0;
      padded_q <= 1'b0;
      fin_q    <= 1'b0;
      blk_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      padded_q <= padded_d;
      fin_q    <= fin_d;
      blk_q    <= blk_d;
    end
  end

  assign Data  = blk_q;
  assign Index = idx_q;

endmodule

// File: tb/tb_sha_1_pad.sv
// Bench for sha_1_pad: standard SHA-1 padding model, a 160-cycle core stand-in,
// and a per-cycle checker for blocks, hold behaviour, In_Ready and Done.
module tb_sha_1_pad;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   In_Data = 8'h00;
  logic         In_Valid = 1'b0;
  logic         In_Last = 1'b0;
  logic         In_Ready;
  logic [511:0] Data;
  logic [63:0]  Index;
  logic         Enable;
  logic         Ready = 1'b0;
  logic         Done;

  sha_1_pad dut (
    .clk(clk), .rst(rst), .In_Data(In_Data), .In_Valid(In_Valid),
    .In_Last(In_Last), .In_Ready(In_Ready), .Data(Data), .Index(Index),
    .Enable(Enable), .Ready(Ready), .Done(Done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] exp_d[$];
  logic [63:0]  exp_i[$];
  bit           exp_l[$];
  logic [511:0] cur_d;
  logic [63:0]  cur_i;
  bit           cur_l;
  bit           busy = 0;
  bit           done_exp = 0;
  int           core_cnt = 0;

  function automatic logic [31:0] wd(input logic [511:0] d, input int i);
    return d[i*32 +: 32];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Standard SHA-1 padding of the whole message, then split into blocks.
  task automatic build();
    logic [7:0]   pb[$];
    logic [63:0]  bits;
    logic [511:0] d;
    int           nb;
    pb = msg_q;
    bits = 64'(msg_q.size()) * 64'd8;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    for (int i = 7; i >= 0; i--) pb.push_back(bits[i*8 +: 8]);
    nb = pb.size() / 64;
    for (int j = 0; j < nb; j++) begin
      d = '0;
      for (int k = 0; k < 64; k++) d[(k/4)*32 + (3 - k%4)*8 +: 8] = pb[j*64 + k];
      exp_d.push_back(d);
      exp_i.push_back(64'(j + 1));
      exp_l.push_back(j == nb - 1);
    end
  endtask

  task automatic send_all();
    int g;
    for (int i = 0; i < msg_q.size(); i++) begin
      g = 0;
      forever begin
        @(negedge clk);
        In_Data  = msg_q[i];
        In_Valid = 1'b1;
        In_Last  = (i == msg_q.size() - 1);
        if (In_Ready) break;
        g++;
        if (g > 2000) begin
          chk("in_ready_timeout", 64'(g), 64'd2000);
          break;
        end
      end
    end
    @(negedge clk);
    In_Valid = 1'b0;
    In_Last  = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!Done && g < 2000);
    chk({nm, "_done_seen"}, 64'(Done), 64'd1);
    chk({nm, "_drained"}, 64'(exp_d.size()), 64'd0);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_in_ready"}, 64'(In_Ready), 64'd1);
    chk({nm, "_enable"}, 64'(Enable), 64'd0);
    chk({nm, "_done"}, 64'(Done), 64'd0);
    chk({nm, "_index"}, Index, 64'd0);
    chk({nm, "_data_or"}, 64'(|Data), 64'd0);
  endtask

  // Core stand-in plus per-cycle output checks.
  always @(negedge clk) begin
    if (!rst) begin
      exp_d.delete(); exp_i.delete(); exp_l.delete();
      busy = 0; done_exp = 0; core_cnt = 0; Ready = 1'b0;
    end else begin
      n_cmp++;
      if (Done !== done_exp) begin
        n_bad++;
        $display("FAIL done_pulse: got %b want %b", Done, done_exp);
      end
      done_exp = 0;
      if (Enable) begin
        if (exp_d.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_enable: got Index %h want no block", Index);
        end else begin
          cur_d = exp_d.pop_front();
          cur_i = exp_i.pop_front();
          cur_l = exp_l.pop_front();
          busy = 1;
          core_cnt = 161;
        end
      end
      if (busy) begin
        n_cmp++;
        if (Data !== cur_d) begin
          n_bad++;
          $display("FAIL block_data: got %h want %h", Data, cur_d);
        end
        chk("block_index", Index, cur_i);
        chk("in_ready_busy", 64'(In_Ready), 64'd0);
      end
      Ready = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          Ready = 1'b1;
          done_exp = cur_l;
          busy = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset("rst0");

    // "abc"
    msg_q = '{8'h61, 8'h62, 8'h63};
    build();
    chk("abc_w0", 64'(wd(exp_d[0], 0)), 64'h61626380);
    chk("abc_w15", 64'(wd(exp_d[0], 15)), 64'h18);
    chk("abc_nblk", 64'(exp_d.size()), 64'd1);
    send_all();
    wait_done("abc");

    // 55 zero bytes: marker and length share the block
    msg_q.delete();
    repeat (55) msg_q.push_back(8'h00);
    build();
    chk("z55_w13", 64'(wd(exp_d[0], 13)), 64'h80);
    chk("z55_w15", 64'(wd(exp_d[0], 15)), 64'h1B8);
    chk("z55_nblk", 64'(exp_d.size()), 64'd1);
    send_all();
    wait_done("z55");

    // 56 bytes: length spills to a second block
    msg_q.delete();
    for (int i = 0; i < 56; i++) msg_q.push_back(8'(i + 1));
    build();
    chk("b56_b0w14", 64'(wd(exp_d[0], 14)), 64'h80000000);
    chk("b56_b0w15", 64'(wd(exp_d[0], 15)), 64'h0);
    chk("b56_b1w0", 64'(wd(exp_d[1], 0)), 64'h0);
    chk("b56_b1w15", 64'(wd(exp_d[1], 15)), 64'h1C0);
    send_all();
    wait_done("b56");

    // 60 bytes: marker lands inside the length slot region
    msg_q.delete();
    for (int i = 0; i < 60; i++) msg_q.push_back(8'(8'hA0 + i));
    build();
    chk("b60_b0w15", 64'(wd(exp_d[0], 15)), 64'h80000000);
    chk("b60_b1w15", 64'(wd(exp_d[1], 15)), 64'h1E0);
    send_all();
    wait_done("b60");

    // 64 bytes, last on the block-full byte
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'(i * 3));
    build();
    chk("b64_b1w0", 64'(wd(exp_d[1], 0)), 64'h80000000);
    chk("b64_b1w15", 64'(wd(exp_d[1], 15)), 64'h200);
    chk("b64_nblk", 64'(exp_d.size()), 64'd2);
    send_all();
    wait_done("b64");

    // 130 bytes with In_Valid held high across backpressure
    msg_q.delete();
    for (int i = 0; i < 130; i++) msg_q.push_back(8'(i * 7 + 3));
    build();
    chk("b130_b2w15", 64'(wd(exp_d[2], 15)), 64'h410);
    chk("b130_nblk", 64'(exp_d.size()), 64'd3);
    send_all();
    wait_done("b130");

    // Reset while waiting on the core, then a clean message
    msg_q = '{8'h61, 8'h62, 8'h63};
    build();
    send_all();
    begin
      int g = 0;
      while (!busy && g < 100) begin @(negedge clk); g++; end
      chk("rstw_reached_wait", 64'(busy), 64'd1);
    end
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset("rstw");
    repeat (300) @(negedge clk);
    msg_q = '{8'h61, 8'h62, 8'h63};
    build();
    chk("abc2_idx", exp_i[0], 64'd1);
    send_all();
    wait_done("abc2");

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
